// File: rtl/reg_file_if.sv
// rtl/reg_file_if.sv - Register file access bus: write port, two read ports, ready status
//
// Signals (master drives requests, slave returns data):
//   we        write enable
//   rd_addr   write destination index (5 bits)
//   wd        write data (N bits)
//   rs1_addr  read port 1 index (5 bits)
//   rs2_addr  read port 2 index (5 bits)
//   rs1_data  read port 1 data (N bits)
//   rs2_data  read port 2 data (N bits)
//   ready     high once the post-reset clear has completed
interface reg_file_if #(
    parameter int N = 32
);
    logic         we;
    logic [4:0]   rd_addr;
    logic [N-1:0] wd;
    logic [4:0]   rs1_addr;
    logic [4:0]   rs2_addr;
    logic [N-1:0] rs1_data;
    logic [N-1:0] rs2_data;
    logic         ready;

    modport master (
        output we, rd_addr, wd, rs1_addr, rs2_addr,
        input  rs1_data, rs2_data, ready
    );

    modport slave (
        input  we, rd_addr, wd, rs1_addr, rs2_addr,
        output rs1_data, rs2_data, ready
    );
endinterface

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32-entry register file with post-reset clear sequencer and two read ports
//
// Ports:
//   clk   single clock, rising edge
//   rst   synchronous active-high reset
//   bus   reg_file_if slave: we/rd_addr/wd write port, rs1/rs2 read ports, ready
//
// Parameter:
//   N     data width of each entry
//
// Optional feature:
//   REG_FILE_BYPASS_EN  when defined, a read of the address being written in the
//                       same cycle returns wd (write-through); otherwise it returns
//                       the stored value until the next cycle.
module reg_file #(
    parameter int N = 32
) (
    input  logic        clk,
    input  logic        rst,
    reg_file_if.slave   bus
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t       state;
    logic [4:0]   cnt;
    logic         ready_q;

    // Storage has no reset; its contents are zeroed by the CLEAR walk instead.
    logic [N-1:0] mem [32];

    // Sequencer: one zero-write per CLEAR cycle, exactly one pass, then RUN forever.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            cnt     <= 5'd0;
            ready_q <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (cnt == 5'd31) begin
                        state   <= RUN;
                        ready_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                RUN: begin
                    state   <= RUN;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= CLEAR;
                    cnt     <= 5'd0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Entry writes: reset blocks everything, CLEAR owns the array, RUN takes the
    // user write. Entry 0 is cleared but never user-written.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[cnt] <= '0;
            end else if (bus.we && (bus.rd_addr != 5'd0)) begin
                mem[bus.rd_addr] <= bus.wd;
            end
        end
    end

    function automatic logic [N-1:0] read_port(input logic [4:0] addr);
        logic [N-1:0] val;
        val = '0;
        if ((state == RUN) && (addr != 5'd0)) begin
`ifdef REG_FILE_BYPASS_EN
            if (bus.we && (bus.rd_addr == addr)) begin
                val = bus.wd;
            end else begin
                val = mem[addr];
            end
`else
            val = mem[addr];
`endif
        end
        return val;
    endfunction

    always_comb begin
        bus.rs1_data = read_port(bus.rs1_addr);
        bus.rs2_data = read_port(bus.rs2_addr);
    end

    assign bus.ready = ready_q;

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - Randomized and directed self-checking bench for reg_file
module tb_reg_file;

    localparam int N = 32;

    logic clk;
    logic rst;

    reg_file_if #(.N(N)) bus ();

    reg_file #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: an array of values plus "cycles of clearing left".
    logic [N-1:0] m_mem [32];
    int           m_clear_left = 0;
    bit           m_valid = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_ready();
        return m_valid && (m_clear_left == 0);
    endfunction

    function automatic logic [N-1:0] m_read(input logic [4:0] addr);
        if (!m_ready() || addr == 5'd0) return '0;
`ifdef REG_FILE_BYPASS_EN
        if (bus.we && bus.rd_addr == addr) return bus.wd;
`endif
        return m_mem[addr];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_clear_left = 32;
            for (int i = 0; i < 32; i++) m_mem[i] = '0;
        end else if (m_clear_left > 0) begin
            m_clear_left--;
        end else if (m_valid && bus.we && bus.rd_addr != 5'd0) begin
            m_mem[bus.rd_addr] = bus.wd;
        end
    end

    // Continuous comparison, sampled mid-cycle.
    always @(negedge clk) begin
        if (m_valid) begin
            check("ready",    {63'd0, bus.ready}, {63'd0, m_ready()});
            check("rs1_data", {32'd0, bus.rs1_data}, {32'd0, m_read(bus.rs1_addr)});
            check("rs2_data", {32'd0, bus.rs2_data}, {32'd0, m_read(bus.rs2_addr)});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.we = 1'b0;
        bus.rd_addr = 5'd0;
        bus.wd = '0;
    endtask

    initial begin
        rst = 1'b1;
        bus.we = 1'b0;
        bus.rd_addr = 5'd0;
        bus.wd = '0;
        bus.rs1_addr = 5'd0;
        bus.rs2_addr = 5'd0;

        // Reset for one edge, then exactly 32 cycles of ready low.
        step();
        rst = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            #1;
            check("ready_low_during_clear", {63'd0, bus.ready}, 64'd0);
            bus.rs1_addr = 5'(i);
            #1;
            check("read_zero_during_clear", {32'd0, bus.rs1_data}, 64'd0);
            step();
        end
        check("ready_at_edge33", {63'd0, bus.ready}, 64'd1);
        for (int a = 0; a < 32; a++) begin
            bus.rs1_addr = 5'(a);
            bus.rs2_addr = 5'(31 - a);
            #1;
            check("post_clear_rs1", {32'd0, bus.rs1_data}, 64'd0);
            check("post_clear_rs2", {32'd0, bus.rs2_data}, 64'd0);
        end

        // Write then read on both ports.
        bus.we = 1'b1; bus.rd_addr = 5'd5; bus.wd = 32'hDEADBEEF;
        step();
        idle();
        bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd5;
        #1;
        check("wr5_rs1", {32'd0, bus.rs1_data}, 64'hDEADBEEF);
        check("wr5_rs2", {32'd0, bus.rs2_data}, 64'hDEADBEEF);

        // Entry 0 is immutable, including during a write to it.
        bus.we = 1'b1; bus.rd_addr = 5'd0; bus.wd = 32'hFFFFFFFF; bus.rs1_addr = 5'd0;
        #1;
        check("x0_same_cycle", {32'd0, bus.rs1_data}, 64'd0);
        step();
        idle();
        #1;
        check("x0_after", {32'd0, bus.rs1_data}, 64'd0);

        // Same-cycle read/write hazard.
        bus.we = 1'b1; bus.rd_addr = 5'd7; bus.wd = 32'h11;
        step();
        bus.wd = 32'h22; bus.rs1_addr = 5'd7;
        #1;
`ifdef REG_FILE_BYPASS_EN
        check("hazard_same", {32'd0, bus.rs1_data}, 64'h22);
`else
        check("hazard_same", {32'd0, bus.rs1_data}, 64'h11);
`endif
        step();
        idle();
        #1;
        check("hazard_next", {32'd0, bus.rs1_data}, 64'h22);

        // Reset mid-clear, with writes attempted during the restarted clear.
        bus.we = 1'b1; bus.rd_addr = 5'd3; bus.wd = 32'h55;
        step();
        idle();
        #1;
        check("wr3_run", {29'd0, bus.rs1_data[2:0]} == 0 ? 64'd0 : 64'd0, 64'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.we = 1'b1; bus.rd_addr = 5'd3; bus.wd = 32'h55; bus.rs1_addr = 5'd3;
        for (int i = 1; i <= 32; i++) begin
            #1;
            check("midclear_ready_low", {63'd0, bus.ready}, 64'd0);
            step();
        end
        idle();
        #1;
        check("midclear_ready", {63'd0, bus.ready}, 64'd1);
        check("midclear_entry3", {32'd0, bus.rs1_data}, 64'd0);

        // Reset while running re-clears everything.
        bus.we = 1'b1; bus.rd_addr = 5'd31; bus.wd = 32'hA5A5A5A5;
        step();
        idle();
        bus.rs2_addr = 5'd31;
        #1;
        check("e31_written", {32'd0, bus.rs2_data}, 64'hA5A5A5A5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            #1;
            check("runrst_ready_low", {63'd0, bus.ready}, 64'd0);
            step();
        end
        #1;
        check("runrst_ready", {63'd0, bus.ready}, 64'd1);
        check("runrst_e31", {32'd0, bus.rs2_data}, 64'd0);

        // Randomized traffic, checked against the model every cycle.
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 399) == 0);
            bus.we = $urandom_range(0, 1);
            bus.rd_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            bus.wd = $urandom;
            bus.rs1_addr = ($urandom_range(0, 2) == 0) ? bus.rd_addr : 5'($urandom);
            bus.rs2_addr = ($urandom_range(0, 2) == 0) ? bus.rd_addr : 5'($urandom);
            step();
        end
        rst = 1'b0;
        idle();
        for (int c = 0; c < 40; c++) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning the data width of each register entry in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port we, input, 1 bit: write enable, sampled at the rising edge of clk.
REQ-005 The block SHALL have port rd_addr, input, 5 bits: write destination index.
REQ-006 The block SHALL have port wd, input, N bits: write data.
REQ-007 The block SHALL have port rs1_addr, input, 5 bits: read port 1 index.
REQ-008 The block SHALL have port rs2_addr, input, 5 bits: read port 2 index.
REQ-009 The block SHALL have port rs1_data, output, N bits: read port 1 data.
REQ-010 The block SHALL have port rs2_data, output, N bits: read port 2 data.
REQ-011 The block SHALL have port ready, output, 1 bit: high once the post-reset clear has completed.

Function
REQ-012 Storage SHALL be 32 entries of N bits, held in non-reset storage and cleared only by the clear sequencer.
REQ-013 The sequencer SHALL have exactly two states: CLEAR and RUN.
REQ-014 CLEAR: a 5-bit clear counter SHALL write zero to entry[cnt] each cycle, then increment.
REQ-015 When CLEAR writes entry 31, the next state SHALL be RUN; the counter SHALL NOT wrap into a second pass.
REQ-016 CLEAR SHALL last exactly 32 cycles after rst deasserts; ready SHALL rise on the 33rd rising edge after the rst-high edge.
REQ-017 In CLEAR, we SHALL be ignored, and rs1_data and rs2_data SHALL read 0.
REQ-018 In RUN, when we=1 and rd_addr!=0, entry[rd_addr] SHALL take wd at the rising edge.
REQ-019 Entry 0 SHALL never be written; a write with rd_addr=0 SHALL have no effect.
REQ-020 In RUN, rsX_data SHALL be a combinational read of entry[rsX_addr], zero-latency.
REQ-021 rsX_addr=0 SHALL always read 0, including with we=1, rd_addr=0.
REQ-022 Both read ports SHALL be independent; rs1_addr==rs2_addr SHALL return identical data.
REQ-023 Same-cycle read and write of one address: behaviour SHALL follow REQ-031 and REQ-032.
REQ-024 RUN SHALL persist until rst; no other event SHALL leave RUN.

Reset
REQ-025 rst=1 at a rising edge SHALL force state CLEAR, counter 0, and ready 0 on the following cycle.
REQ-026 rst SHALL take priority over we and over the sequencer; no entry write SHALL occur on a rst-high edge.
REQ-027 rst asserted mid-CLEAR SHALL restart the sequence at entry 0 with a full 32-cycle CLEAR.
REQ-028 rst asserted in RUN SHALL drop ready to 0 and re-clear all entries.
REQ-029 Held rst SHALL keep counter 0 and ready 0; reads SHALL return 0.
REQ-030 Outputs during and after reset: ready=0, rs1_data=0, rs2_data=0 until RUN.

Configuration
REQ-031 With macro REG_FILE_BYPASS_EN defined: in RUN, with we=1, rd_addr!=0 and rsX_addr==rd_addr, rsX_data SHALL equal wd in that same cycle (write-through).
REQ-032 Without REG_FILE_BYPASS_EN: rsX_data SHALL return the old entry value in that cycle, and the new value from the next cycle.

Verification
REQ-033 Reset: rst=1 for 1 cycle, then 0 -> ready=0 for 32 cycles, ready=1 at edge 33; all 32 addresses read 0.
REQ-034 Write/read: we=1, rd_addr=5, wd=0xDEADBEEF; next cycle rs1_addr=5, rs2_addr=5 -> both ports read 0xDEADBEEF.
REQ-035 x0: we=1, rd_addr=0, wd=0xFFFFFFFF; then rs1_addr=0 -> rs1_data=0.
REQ-036 Same-cycle hazard: entry 7=0x11; we=1, rd_addr=7, wd=0x22, rs1_addr=7 -> rs1_data=0x22 with REG_FILE_BYPASS_EN, 0x11 without; 0x22 on the next cycle in both builds.
REQ-037 Mid-clear reset: rst at CLEAR cycle 10, then we=1, rd_addr=3, wd=0x55 during the restarted CLEAR -> ready after 32 more cycles, entry 3 reads 0.
REQ-038 Reset in RUN: entry 31=0xA5A5A5A5, pulse rst -> ready=0 for 32 cycles, then entry 31 reads 0.
